pdm_ramp: RTL and testbench

PDM_RAMP -- requirements
Module: pdm_ramp

---
 rtl/pdm_pkg.sv | 13 +
 rtl/pdm_tick.sv | 34 +++
 rtl/pdm_ramp.sv | 102 ++++++++++
 tb/tb_pdm_ramp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and default sizes for the PDM setpoint ramp generator.
// Other files import this package.
package pdm_pkg;

  localparam int NBITS_DEF     = 11;
  localparam int DIV_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/pdm_tick.sv
// Period counter: counts 0..period-1 while enabled and flags the wrap cycle.
// Holding clear keeps it parked at 0.
module pdm_tick
  import pdm_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] last;

  // period is never 0 here; the caller maps 0 to 1
  assign last = period - ONE;
  assign tick = !clear && (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pdm_ramp.sv
// Ramps a PDM setpoint toward a requested target by a fixed step
// every period clocks, clamping at the target without wrapping.
module pdm_ramp
  import pdm_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBITS-1:0]     target,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic [NBITS-1:0]     step,
  input  logic [DIV_WIDTH-1:0] period,
  output logic [NBITS-1:0]     dout,
  output logic                 busy,
  output logic                 done
);

  localparam logic [NBITS-1:0]     S_ONE = {{(NBITS-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] P_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [NBITS-1:0]     tgt_q;
  logic [NBITS-1:0]     step_q;
  logic [DIV_WIDTH-1:0] per_q;
  logic                 accept;
  logic                 clear;
  logic                 tick;
  logic [NBITS:0]       up;
  logic [NBITS:0]       dn;
  logic [NBITS-1:0]     nxt;

  assign accept = target_valid && target_ready;
  assign clear  = (state != RAMP);
  assign busy   = (state == RAMP);

  pdm_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .period(per_q),
    .tick  (tick)
  );

  // One extra bit catches both overflow past full scale and borrow below 0
  always_comb begin
    up  = {1'b0, dout} + {1'b0, step_q};
    dn  = {1'b0, dout} - {1'b0, step_q};
    nxt = tgt_q;
    if (tgt_q > dout) begin
      if (up < {1'b0, tgt_q}) nxt = up[NBITS-1:0];
    end else begin
      if (!dn[NBITS] && (dn[NBITS-1:0] > tgt_q)) nxt = dn[NBITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dout         <= '0;
      done         <= 1'b0;
      target_ready <= 1'b0;
      tgt_q        <= '0;
      step_q       <= S_ONE;
      per_q        <= P_ONE;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          target_ready <= 1'b1;
          if (accept) begin
            tgt_q  <= target;
            step_q <= (step == '0) ? S_ONE : step;
            per_q  <= (period == '0) ? P_ONE : period;
            if (target == dout) begin
              done <= 1'b1;
            end else begin
              state        <= RAMP;
              target_ready <= 1'b0;
            end
          end
        end
        RAMP: begin
          if (tick) begin
            dout <= nxt;
            if (nxt == tgt_q) begin
              state        <= IDLE;
              done         <= 1'b1;
              target_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_ramp.sv
// Scoreboard bench for pdm_ramp: a request model predicts every dout
// change and done pulse with their cycle; a negedge monitor checks them.
module tb_pdm_ramp;

  localparam int NB = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] target = '0;
  logic          target_valid = 1'b0;
  logic          target_ready;
  logic [NB-1:0] step = '0;
  logic [DW-1:0] period = '0;
  logic [NB-1:0] dout;
  logic          busy;
  logic          done;

  pdm_ramp #(
    .NBITS    (NB),
    .DIV_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .target      (target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .step        (step),
    .period      (period),
    .dout        (dout),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t val_q[$];
  int  done_q[$];
  ev_t e;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  prev = 0;
  int  model = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(dout) != prev) begin
        if (val_q.size() == 0) begin
          chk("unexpected_dout_change", int'(dout), prev);
        end else begin
          e = val_q.pop_front();
          chk("dout_value", int'(dout), e.val);
          chk("dout_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", int'(done), 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      chk("ready_and_busy", int'(busy && target_ready), 0);
      chk("done_without_ready", int'(done && !target_ready), 0);
    end
    prev = int'(dout);
  end

  task automatic request(input int t, input int s, input int p, input int spam);
    int acc, v, se, pe, k, n, bound;
    ev_t x;
    n = 0;
    @(negedge clk);
    while (!target_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!target_ready) chk("ready_timeout", int'(target_ready), 1);
    target       = NB'(t);
    step         = NB'(s);
    period       = DW'(p);
    target_valid = 1'b1;
    acc = cyc + 1;
    se  = (s == 0) ? 1 : s;
    pe  = (p == 0) ? 1 : p;
    v   = model;
    if (t == v) begin
      done_q.push_back(acc);
    end else begin
      k = 0;
      while (v != t) begin
        k++;
        if (t > v) v = (v + se > t) ? t : v + se;
        else       v = (v - se < t) ? t : v - se;
        x.cyc = acc + k * pe;
        x.val = v;
        val_q.push_back(x);
      end
      done_q.push_back(acc + k * pe);
    end
    model = t;
    @(posedge clk);
    #1 target_valid = 1'b0;
    if (spam > 0) begin
      target       = NB'(7);
      step         = NB'(1);
      period       = DW'(1);
      target_valid = 1'b1;
      repeat (spam) @(negedge clk);
      target_valid = 1'b0;
    end
    bound = 2100 * (pe + 1) + 20;
    n = 0;
    while ((val_q.size() != 0 || done_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", val_q.size() + done_q.size(), 0);
    val_q.delete();
    done_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(target_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(target_ready), 1);
    mon_en = 1'b1;

    request(100, 10, 4, 5);
    request(95, 10, 1, 0);
    request(50, 50, 1, 0);
    request(50, 7, 3, 0);
    chk("equal_no_busy", int'(busy), 0);
    request(2040, 2047, 1, 0);
    request(2047, 100, 2, 0);
    chk("top_no_wrap", int'(dout), 2047);
    request(0, 2047, 1, 0);
    request(3, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 5) == 0)
        request(model, $urandom_range(0, 300), $urandom_range(0, 3), 0);
      else
        request($urandom_range(0, 2047), $urandom_range(0, 300),
                $urandom_range(0, 3), $urandom_range(0, 2));
    end
    request(0, 2047, 1, 0);

    // abort a ramp with reset at dout = 30
    mon_en = 1'b0;
    @(negedge clk);
    target       = NB'(100);
    step         = NB'(10);
    period       = DW'(2);
    target_valid = 1'b1;
    @(posedge clk);
    #1 target_valid = 1'b0;
    @(negedge clk);
    target       = NB'(5);
    target_valid = 1'b1;
    n = 0;
    while (dout != NB'(30) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_30", int'(dout), 30);
    chk("abort_busy", int'(busy), 1);
    rst          = 1'b1;
    target_valid = 1'b0;
    @(negedge clk);
    chk("abort_dout", int'(dout), 0);
    chk("abort_busy_clr", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(target_ready), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      chk("abort_hold_dout", int'(dout), 0);
      chk("abort_ready_back", int'(target_ready), 1);
    end
    model  = 0;
    mon_en = 1'b1;
    request(20, 5, 1, 0);

    chk("final_queues", val_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
